trail_stack: RTL and testbench

TRAIL_STACK -- requirements
Module: trail_stack

---
 rtl/trail_pkg.sv | 25 ++
 rtl/trail_stack_if.sv | 41 ++++
 rtl/trail_mem.sv | 24 ++
 rtl/trail_stack.sv | 141 ++++++++++++++
 tb/tb_trail_stack.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/trail_pkg.sv
// Shared types and constants for the assignment trail stack.
// Holds the entry layout, the controller state encoding and the entry type codes.
// Ports: none (package).
package trail_pkg;

   // Widest variable index the entry struct can carry. The datapath itself is
   // sized by the VAR_W parameter of trail_stack.
   localparam int VAR_W_MAX = 16;

   // Entry type codes carried in the type field.
   localparam logic DECIDE = 1'b0;
   localparam logic FORCED = 1'b1;

   typedef struct packed {
      logic                 etype;  // DECIDE or FORCED
      logic                 val;    // assigned truth value
      logic [VAR_W_MAX-1:0] vidx;   // variable index, zero-extended
   } entry_t;

   typedef enum logic {
      IDLE   = 1'b0,
      UNWIND = 1'b1
   } state_t;

endpackage

// File: rtl/trail_stack_if.sv
// Command/response bundle between a trail_stack and whoever drives it.
// master drives push/pop/backtrack and the entry fields; slave (the stack) drives
// ready, the popped entry with out_valid/out_last, and the occupancy status.
interface trail_stack_if #(
   parameter int VAR_W = 8,
   parameter int DEPTH = 128
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic             push;
   logic             pop;
   logic             backtrack;
   logic             type_in;
   logic             val_in;
   logic [VAR_W-1:0] var_in;

   logic             ready;
   logic             out_valid;
   logic             type_out;
   logic             val_out;
   logic [VAR_W-1:0] var_out;
   logic             out_last;
   logic [CW-1:0]    count;
   logic [CW-1:0]    level;
   logic             empty;
   logic             full;
   logic             overflow;

   modport master (
      output push, pop, backtrack, type_in, val_in, var_in,
      input  ready, out_valid, type_out, val_out, var_out, out_last,
      input  count, level, empty, full, overflow
   );

   modport slave (
      input  push, pop, backtrack, type_in, val_in, var_in,
      output ready, out_valid, type_out, val_out, var_out, out_last,
      output count, level, empty, full, overflow
   );

endinterface

// File: rtl/trail_mem.sv
// Entry storage for the trail stack: one synchronous write port, one combinational read port.
// Ports: clock; we/waddr/wdata write on the rising edge; raddr -> rdata is combinational.
// Contents are deliberately not reset; only locations below the stack count are ever read.
module trail_mem #(
   parameter int W     = 10,
   parameter int DEPTH = 128,
   parameter int AW    = 7
) (
   input  logic          clock,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [W-1:0]  wdata,
   input  logic [AW-1:0] raddr,
   output logic [W-1:0]  rdata
);
   logic [W-1:0] mem [DEPTH];

   always_ff @(posedge clock) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/trail_stack.sv
// Assignment trail stack: push/pop entries, or backtrack down to the newest decide entry.
// Ports: clock, reset (sync, active-high), bus (trail_stack_if.slave). Popped entries are
// registered (1 cycle after the pop edge); commands are taken only while ready (IDLE).
module trail_stack
   import trail_pkg::*;
#(
   parameter int VAR_W = 8,
   parameter int DEPTH = 128
) (
   input  logic         clock,
   input  logic         reset,
   trail_stack_if.slave bus
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH) + 1;
   localparam int W  = VAR_W + 2;

   state_t           state;
   logic [CW-1:0]    count;
   logic [CW-1:0]    level;
   logic [CW-1:0]    count_m1;
   logic             overflow_q;
   logic             out_valid_q;
   logic             out_last_q;
   logic             out_type_q;
   logic             out_val_q;
   logic [VAR_W-1:0] out_var_q;

   logic             is_empty, is_full;
   logic [AW-1:0]    top_addr, wr_addr;
   logic [W-1:0]     rd_data, wr_data;
   logic             top_dec, new_dec;
   logic             cmd_bt, cmd_rep, cmd_pop, cmd_push, cmd_ovf;
   logic             unwind_pop, take, wr_en, lvl_up, lvl_dn;

   assign is_empty = (count == '0);
   assign is_full  = (count == CW'(DEPTH));
   assign count_m1 = count - CW'(1);
   assign top_addr = count_m1[AW-1:0];

   // Stored word layout: {type, val, var}. The read port always looks at the top entry.
   assign wr_data = {bus.type_in, bus.val_in, bus.var_in};
   assign top_dec = (rd_data[VAR_W+1] == DECIDE);
   assign new_dec = (bus.type_in != FORCED);

   // Command decode, priority backtrack > push&pop > pop > push; nothing is taken in UNWIND.
   always_comb begin
      cmd_bt   = 1'b0;
      cmd_rep  = 1'b0;
      cmd_pop  = 1'b0;
      cmd_push = 1'b0;
      cmd_ovf  = 1'b0;
      if (state == IDLE) begin
         if (bus.backtrack) begin
            cmd_bt = !is_empty;
         end else if (bus.push && bus.pop) begin
            // An empty stack cannot be full, so the push-only fallback always fits.
            cmd_push = is_empty;
            cmd_rep  = !is_empty;
         end else if (bus.pop) begin
            cmd_pop = !is_empty;
         end else if (bus.push) begin
            cmd_push = !is_full;
            cmd_ovf  = is_full;
         end
      end
   end

   assign unwind_pop = (state == UNWIND);
   assign take       = cmd_rep | cmd_pop | unwind_pop;
   assign wr_en      = cmd_push | cmd_rep;
   // A replace overwrites the top slot; its old contents are read out in the same cycle.
   assign wr_addr    = cmd_rep ? top_addr : count[AW-1:0];
   assign lvl_up     = wr_en & new_dec;
   assign lvl_dn     = take & top_dec & (level != '0);

   trail_mem #(
      .W     (W),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_mem (
      .clock (clock),
      .we    (wr_en),
      .waddr (wr_addr),
      .wdata (wr_data),
      .raddr (top_addr),
      .rdata (rd_data)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= IDLE;
         count       <= '0;
         level       <= '0;
         overflow_q  <= 1'b0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         out_type_q  <= 1'b0;
         out_val_q   <= 1'b0;
         out_var_q   <= '0;
      end else begin
         out_valid_q <= take;
         // Single pops/replaces are always last; an unwind ends on a decide or the bottom entry.
         out_last_q  <= take & (cmd_rep | cmd_pop | top_dec | (count == CW'(1)));
         out_type_q  <= take & rd_data[VAR_W+1];
         out_val_q   <= take & rd_data[VAR_W];
         out_var_q   <= take ? rd_data[VAR_W-1:0] : '0;

         if (cmd_ovf) overflow_q <= 1'b1;

         case (state)
            IDLE:    if (cmd_bt) state <= UNWIND;
            UNWIND:  if (top_dec || count == CW'(1)) state <= IDLE;
            default: state <= IDLE;
         endcase

         if (cmd_push)
            count <= count + CW'(1);
         else if (cmd_pop || unwind_pop)
            count <= count - CW'(1);

         if (lvl_up && !lvl_dn)
            level <= level + CW'(1);
         else if (lvl_dn && !lvl_up)
            level <= level - CW'(1);
      end
   end

   assign bus.ready     = (state == IDLE);
   assign bus.out_valid = out_valid_q;
   assign bus.out_last  = out_last_q;
   assign bus.type_out  = out_type_q;
   assign bus.val_out   = out_val_q;
   assign bus.var_out   = out_var_q;
   assign bus.count     = count;
   assign bus.level     = level;
   assign bus.empty     = is_empty;
   assign bus.full      = is_full;
   assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_trail_stack.sv
// Bench for trail_stack: queue-based reference model, scoreboard of expected pops,
// a negedge monitor comparing outputs/status, directed scenarios then random traffic.
module tb_trail_stack;
   import trail_pkg::*;

   localparam int VW = 8;
   localparam int DP = 12;

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   trail_stack_if #(.VAR_W(VW), .DEPTH(DP)) bus ();

   trail_stack #(.VAR_W(VW), .DEPTH(DP)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      entry_t e;
      bit     last;
   } exp_t;

   entry_t     stk[$];      // model stack, back = top
   exp_t       expq[$];     // scoreboard of expected pops
   bit         unw = 1'b0;  // model is unwinding
   bit         ovf = 1'b0;

   int         checks = 0;
   int         failures = 0;
   int         cyc = 0;
   int         ready_low = 0;
   bit [VW-1:0] obs_var[$];
   bit         obs_last[$];
   int         obs_cyc[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
      end
   endtask

   function automatic int n_dec();
      int n = 0;
      foreach (stk[i]) if (stk[i].etype == DECIDE) n++;
      return n;
   endfunction

   // Reference model: stack semantics from the command rules, applied once per edge.
   always @(posedge clock) begin
      entry_t ne, e;
      bit     p, q, b;
      p  = bus.push;
      q  = bus.pop;
      b  = bus.backtrack;
      ne = '{etype: bus.type_in, val: bus.val_in, vidx: VAR_W_MAX'(bus.var_in)};
      if (reset) begin
         stk.delete();
         expq.delete();
         unw = 1'b0;
         ovf = 1'b0;
      end else if (unw) begin
         e = stk.pop_back();
         expq.push_back('{e: e, last: (e.etype == DECIDE) || (stk.size() == 0)});
         if ((e.etype == DECIDE) || (stk.size() == 0)) unw = 1'b0;
      end else if (b) begin
         if (stk.size() != 0) unw = 1'b1;
      end else if (p && q && stk.size() != 0) begin
         e = stk.pop_back();
         expq.push_back('{e: e, last: 1'b1});
         stk.push_back(ne);
      end else if (q && !p) begin
         if (stk.size() != 0) begin
            e = stk.pop_back();
            expq.push_back('{e: e, last: 1'b1});
         end
      end else if (p) begin
         if (stk.size() == DP) ovf = 1'b1;
         else stk.push_back(ne);
      end
   end

   // Monitor: every output cycle is compared against the scoreboard and the model state.
   always @(negedge clock) begin
      exp_t x;
      cyc++;
      if (bus.ready !== 1'b1) ready_low++;
      if (bus.out_valid === 1'b1) begin
         obs_var.push_back(bus.var_out);
         obs_last.push_back(bus.out_last);
         obs_cyc.push_back(cyc);
      end
      chk("out_valid", bus.out_valid, expq.size() != 0);
      if (expq.size() != 0) begin
         x = expq.pop_front();
         if (bus.out_valid === 1'b1) begin
            chk("type_out", bus.type_out, x.e.etype);
            chk("val_out",  bus.val_out,  x.e.val);
            chk("var_out",  bus.var_out,  x.e.vidx);
            chk("out_last", bus.out_last, x.last);
         end
      end else begin
         chk("idle_entry", {bus.out_last, bus.type_out, bus.val_out, bus.var_out}, 0);
      end
      chk("count",    bus.count,    stk.size());
      chk("level",    bus.level,    n_dec());
      chk("empty",    bus.empty,    stk.size() == 0);
      chk("full",     bus.full,     stk.size() == DP);
      chk("overflow", bus.overflow, ovf);
      chk("ready",    bus.ready,    !unw);
   end

   task automatic drive(input bit p, input bit q, input bit b,
                        input bit t, input bit v, input bit [VW-1:0] x);
      @(negedge clock);
      #1;
      bus.push      = p;
      bus.pop       = q;
      bus.backtrack = b;
      bus.type_in   = t;
      bus.val_in    = v;
      bus.var_in    = x;
   endtask

   task automatic nop();                                        drive(0, 0, 0, 0, 0, 0); endtask
   task automatic do_push(input bit t, input bit v, input bit [VW-1:0] x); drive(1, 0, 0, t, v, x); endtask
   task automatic do_pp(input bit t, input bit v, input bit [VW-1:0] x);   drive(1, 1, 0, t, v, x); endtask
   task automatic do_pop();                                     drive(0, 1, 0, 0, 0, 0); endtask
   task automatic do_bt();                                      drive(0, 0, 1, 0, 0, 0); endtask

   task automatic clear_obs();
      obs_var.delete();
      obs_last.delete();
      obs_cyc.delete();
      ready_low = 0;
   endtask

   // Idle until the model has nothing in flight; an expired budget counts as a failure.
   task automatic settle();
      int n = 0;
      nop();
      while ((unw || expq.size() != 0) && n < 60) begin
         nop();
         n++;
      end
      chk("settle_timeout", n < 60, 1);
   endtask

   task automatic do_reset();
      @(negedge clock);
      #1;
      reset = 1'b1;
      bus.push = 0; bus.pop = 0; bus.backtrack = 0;
      @(negedge clock);
      #1;
      reset = 1'b0;
   endtask

   task automatic chk_consecutive();
      for (int i = 1; i < obs_cyc.size(); i++)
         chk("consecutive", obs_cyc[i] - obs_cyc[i-1], 1);
   endtask

   initial begin
      bus.push = 0; bus.pop = 0; bus.backtrack = 0;
      bus.type_in = 0; bus.val_in = 0; bus.var_in = 0;
      reset = 1'b1;
      repeat (2) @(posedge clock);
      #1;
      // Reset state
      chk("rst_count", bus.count, 0);
      chk("rst_level", bus.level, 0);
      chk("rst_empty", bus.empty, 1);
      chk("rst_ready", bus.ready, 1);
      chk("rst_outv",  bus.out_valid, 0);
      reset = 1'b0;

      // Three entries, bottom decide: unwind all of them, newest first
      do_push(DECIDE, 1, 5); do_push(FORCED, 0, 6); do_push(FORCED, 1, 7);
      nop(); clear_obs();
      do_bt(); settle();
      chk("bt3_n", obs_var.size(), 3);
      if (obs_var.size() == 3) begin
         chk("bt3_0", obs_var[0], 7); chk("bt3_1", obs_var[1], 6); chk("bt3_2", obs_var[2], 5);
         chk("bt3_last", {obs_last[0], obs_last[1], obs_last[2]}, 3'b001);
      end
      chk_consecutive();
      chk("bt3_count", bus.count, 0);
      chk("bt3_level", bus.level, 0);

      // Unwind stops at the newest decide entry
      do_reset();
      do_push(DECIDE, 0, 1); do_push(FORCED, 0, 2); do_push(DECIDE, 0, 3); do_push(FORCED, 0, 4);
      nop(); clear_obs();
      do_bt(); settle();
      chk("bt2_n", obs_var.size(), 2);
      if (obs_var.size() == 2) begin
         chk("bt2_0", obs_var[0], 4); chk("bt2_1", obs_var[1], 3);
      end
      chk_consecutive();
      chk("bt2_ready_low", ready_low, 2);
      chk("bt2_count", bus.count, 2);
      chk("bt2_level", bus.level, 1);

      // Fill, overflow, then pop: overflow is sticky
      do_reset();
      for (int i = 0; i < DP; i++) do_push(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), VW'(i + 20));
      do_push(FORCED, 0, 99);
      nop();
      chk("fill_full", bus.full, 1);
      chk("fill_ovf", bus.overflow, 1);
      chk("fill_count", bus.count, DP);
      do_pop(); nop();
      chk("pop_full", bus.full, 0);
      chk("pop_ovf", bus.overflow, 1);
      chk("pop_count", bus.count, DP - 1);

      // Empty: pop and backtrack ignored; push+pop acts as a push
      do_reset(); clear_obs();
      do_pop(); do_bt(); nop(); nop();
      chk("empty_nout", obs_var.size(), 0);
      chk("empty_ready_low", ready_low, 0);
      do_pp(FORCED, 0, 9); nop();
      chk("pp_empty_count", bus.count, 1);
      chk("pp_empty_nout", obs_var.size(), 0);

      // Replace a forced top with a decide
      do_pp(DECIDE, 1, 3); nop(); nop();
      chk("rep_n", obs_var.size(), 1);
      if (obs_var.size() == 1) begin
         chk("rep_var", obs_var[0], 9);
         chk("rep_last", obs_last[0], 1);
      end
      chk("rep_count", bus.count, 1);
      chk("rep_level", bus.level, 1);

      // Reset lands in the second cycle of a four-entry unwind
      do_reset();
      do_push(DECIDE, 0, 1); do_push(FORCED, 0, 2); do_push(FORCED, 1, 3); do_push(FORCED, 0, 4);
      nop(); clear_obs();
      do_bt(); nop();
      @(negedge clock); #1; reset = 1'b1;
      @(negedge clock); #1;
      chk("rstmid_n", obs_var.size(), 1);
      chk("rstmid_outv", bus.out_valid, 0);
      chk("rstmid_count", bus.count, 0);
      chk("rstmid_ready", bus.ready, 1);
      reset = 1'b0;

      // Random traffic, including commands while busy and occasional resets
      for (int i = 0; i < 3000; i++) begin
         drive($urandom_range(0, 99) < 50, $urandom_range(0, 99) < 30, $urandom_range(0, 99) < 8,
               1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)), VW'($urandom));
         reset = ($urandom_range(0, 399) == 0);
      end
      reset = 1'b0;
      settle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog_timeout actual=running required=finished");
      $fatal(1, "watchdog");
   end

endmodule
